// File: rtl/hilo_seq.sv
// ============================================================================
// hilo_seq -- HI/LO register sequencer for a MIPS-style multiply/divide unit
// ----------------------------------------------------------------------------
// Purpose
//   Owns the architectural HI and LO registers. On a start request it launches
//   either the external divider or the external multiplier with a one-cycle
//   start pulse. It then waits for completion and latches the 64-bit result
//   into HI/LO. It also services mthi/mtlo writes while idle.
//
// Optional feature (compile-time macro)
//   HILO_SEQ_TIMEOUT_EN : when defined, a watchdog aborts a wait that lasts
//                         TIMEOUT_CYCLES cycles and raises timeout_exc.
//                         When undefined, the wait is unbounded and
//                         timeout_exc is tied low.
//
// Parameters
//   TIMEOUT_CYCLES : maximum number of wait cycles before the watchdog abort.
//
// Ports
//   clk          in   single clock, all state changes on the rising edge
//   reset        in   asynchronous, active-high reset
//   start_div    in   request a signed divide (sampled only in IDLE)
//   start_mult   in   request a multiply (sampled only in IDLE, lower priority)
//   divControl   out  one-cycle start pulse to the divider
//   multControl  out  one-cycle start pulse to the multiplier
//   divStop      in   divider finished
//   divZero      in   divider saw a zero divisor
//   div_hi/lo    in   divider remainder / quotient (signed, passed unmodified)
//   multStop     in   multiplier finished
//   mult_hi/lo   in   multiplier product halves
//   hi_wr/lo_wr  in   mthi / mtlo write strobes (honoured only in IDLE)
//   wr_data      in   data for mthi / mtlo
//   hi/lo        out  architectural HI / LO registers
//   busy         out  high in every state except IDLE
//   done         out  high for the single DONE cycle
//   div_zero_exc out  last divide hit a zero divisor (held until next start)
//   timeout_exc  out  last wait was aborted by the watchdog (held until next start)
// ============================================================================
module hilo_seq #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_div,
    input  logic        start_mult,
    output logic        divControl,
    output logic        multControl,
    input  logic        divStop,
    input  logic        divZero,
    input  logic [31:0] div_hi,
    input  logic [31:0] div_lo,
    input  logic        multStop,
    input  logic [31:0] mult_hi,
    input  logic [31:0] mult_lo,
    input  logic        hi_wr,
    input  logic        lo_wr,
    input  logic [31:0] wr_data,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        div_zero_exc,
    output logic        timeout_exc
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WAIT_DIV  = 2'd1;
    localparam logic [1:0] ST_WAIT_MULT = 2'd2;
    localparam logic [1:0] ST_DONE      = 2'd3;

    // A watchdog limit below one cycle cannot be honoured; stop elaboration.
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("hilo_seq: TIMEOUT_CYCLES must be at least 1");
    end

    // ------------------------------------------------------------------------
    // Registers and next-state wires
    // ------------------------------------------------------------------------
    logic [1:0]  r_state;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_div_ctrl;
    logic        r_mult_ctrl;
    logic        r_busy;
    logic        r_done;
    logic        r_div_zero_exc;

    logic [1:0]  w_state_nxt;
    logic [31:0] w_hi_nxt;
    logic [31:0] w_lo_nxt;
    logic        w_div_ctrl_nxt;
    logic        w_mult_ctrl_nxt;
    logic        w_div_zero_exc_nxt;

    // The start pulse is high exactly during the first wait cycle, so it
    // doubles as the marker that the stop/zero inputs are still stale.
    logic        w_first_wait;

`ifdef HILO_SEQ_TIMEOUT_EN
    // Counter holds the number of wait cycles already completed; it must be
    // wide enough to represent TIMEOUT_CYCLES - 1.
    localparam int             WD_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);
    localparam logic [WD_W-1:0] WD_ZERO = WD_W'(0);

    logic [WD_W-1:0] r_wd_cnt;
    logic [WD_W-1:0] w_wd_cnt_nxt;
    logic            r_timeout_exc;
    logic            w_timeout_exc_nxt;
    logic            w_wd_expired;

    // The current wait cycle is the last one allowed by the watchdog.
    assign w_wd_expired = (r_wd_cnt == WD_LAST);
`endif

    assign w_first_wait = r_div_ctrl | r_mult_ctrl;

    // ------------------------------------------------------------------------
    // Next-state, result-latch and exception logic
    // ------------------------------------------------------------------------
    // Sequencer decision: start acceptance, completion, watchdog abort.
    always_comb begin
        w_state_nxt        = r_state;
        w_hi_nxt           = r_hi;
        w_lo_nxt           = r_lo;
        w_div_ctrl_nxt     = 1'b0;
        w_mult_ctrl_nxt    = 1'b0;
        w_div_zero_exc_nxt = r_div_zero_exc;
`ifdef HILO_SEQ_TIMEOUT_EN
        w_wd_cnt_nxt       = r_wd_cnt;
        w_timeout_exc_nxt  = r_timeout_exc;
`endif

        case (r_state)
            ST_IDLE: begin
                // mthi/mtlo are only architectural moves while idle; a start
                // in the same cycle is still accepted alongside the write.
                if (hi_wr) begin
                    w_hi_nxt = wr_data;
                end else begin
                    w_hi_nxt = r_hi;
                end
                if (lo_wr) begin
                    w_lo_nxt = wr_data;
                end else begin
                    w_lo_nxt = r_lo;
                end

                // Divide wins when both requests arrive together.
                if (start_div) begin
                    w_state_nxt        = ST_WAIT_DIV;
                    w_div_ctrl_nxt     = 1'b1;
                    w_div_zero_exc_nxt = 1'b0;
`ifdef HILO_SEQ_TIMEOUT_EN
                    w_wd_cnt_nxt       = WD_ZERO;
                    w_timeout_exc_nxt  = 1'b0;
`endif
                end else if (start_mult) begin
                    w_state_nxt        = ST_WAIT_MULT;
                    w_mult_ctrl_nxt    = 1'b1;
                    w_div_zero_exc_nxt = 1'b0;
`ifdef HILO_SEQ_TIMEOUT_EN
                    w_wd_cnt_nxt       = WD_ZERO;
                    w_timeout_exc_nxt  = 1'b0;
`endif
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end

            ST_WAIT_DIV: begin
                // A zero divisor outranks a (possibly stale) divStop.
                if (!w_first_wait && divZero) begin
                    w_state_nxt        = ST_DONE;
                    w_div_zero_exc_nxt = 1'b1;
                end else if (!w_first_wait && divStop) begin
                    w_state_nxt = ST_DONE;
                    w_hi_nxt    = div_hi;
                    w_lo_nxt    = div_lo;
                end else begin
`ifdef HILO_SEQ_TIMEOUT_EN
                    // Completion was checked first, so it wins over expiry.
                    if (w_wd_expired) begin
                        w_state_nxt       = ST_DONE;
                        w_timeout_exc_nxt = 1'b1;
                    end else begin
                        w_wd_cnt_nxt = r_wd_cnt + WD_ONE;
                    end
`else
                    w_state_nxt = ST_WAIT_DIV;
`endif
                end
            end

            ST_WAIT_MULT: begin
                if (!w_first_wait && multStop) begin
                    w_state_nxt = ST_DONE;
                    w_hi_nxt    = mult_hi;
                    w_lo_nxt    = mult_lo;
                end else begin
`ifdef HILO_SEQ_TIMEOUT_EN
                    if (w_wd_expired) begin
                        w_state_nxt       = ST_DONE;
                        w_timeout_exc_nxt = 1'b1;
                    end else begin
                        w_wd_cnt_nxt = r_wd_cnt + WD_ONE;
                    end
`else
                    w_state_nxt = ST_WAIT_MULT;
`endif
                end
            end

            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end

            default: begin
                // Unreachable encodings recover to a safe idle state.
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    // Main sequencer registers; busy/done are decoded from the next state so
    // they change on the same edge as the state itself.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_hi           <= 32'h0000_0000;
            r_lo           <= 32'h0000_0000;
            r_div_ctrl     <= 1'b0;
            r_mult_ctrl    <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_div_zero_exc <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_hi           <= w_hi_nxt;
            r_lo           <= w_lo_nxt;
            r_div_ctrl     <= w_div_ctrl_nxt;
            r_mult_ctrl    <= w_mult_ctrl_nxt;
            r_busy         <= (w_state_nxt != ST_IDLE);
            r_done         <= (w_state_nxt == ST_DONE);
            r_div_zero_exc <= w_div_zero_exc_nxt;
        end
    end

`ifdef HILO_SEQ_TIMEOUT_EN
    // Watchdog counter and its sticky exception flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wd_cnt      <= WD_ZERO;
            r_timeout_exc <= 1'b0;
        end else begin
            r_wd_cnt      <= w_wd_cnt_nxt;
            r_timeout_exc <= w_timeout_exc_nxt;
        end
    end

    assign timeout_exc = r_timeout_exc;
`else
    assign timeout_exc = 1'b0;
`endif

    assign hi           = r_hi;
    assign lo           = r_lo;
    assign divControl   = r_div_ctrl;
    assign multControl  = r_mult_ctrl;
    assign busy         = r_busy;
    assign done         = r_done;
    assign div_zero_exc = r_div_zero_exc;

endmodule

// File: tb/tb_hilo_seq.sv
// ============================================================================
// tb_hilo_seq -- self-checking bench for hilo_seq
// The bench plays the roles of the divider and multiplier. Expected HI/LO and
// exception flags come from a small architectural model: signed a%b / a/b for
// divides, the driven product for multiplies, wr_data for idle mthi/mtlo.
// Inputs are driven and outputs sampled on the falling clock edge.
// ============================================================================
module tb_hilo_seq;

`ifdef HILO_SEQ_TIMEOUT_EN
    localparam int TO_CYC = 8;
`else
    localparam int TO_CYC = 64;
`endif

    logic        clk;
    logic        reset;
    logic        start_div;
    logic        start_mult;
    logic        divControl;
    logic        multControl;
    logic        divStop;
    logic        divZero;
    logic [31:0] div_hi;
    logic [31:0] div_lo;
    logic        multStop;
    logic [31:0] mult_hi;
    logic [31:0] mult_lo;
    logic        hi_wr;
    logic        lo_wr;
    logic [31:0] wr_data;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_zero_exc;
    logic        timeout_exc;

    hilo_seq #(.TIMEOUT_CYCLES(TO_CYC)) dut (
        .clk          (clk),
        .reset        (reset),
        .start_div    (start_div),
        .start_mult   (start_mult),
        .divControl   (divControl),
        .multControl  (multControl),
        .divStop      (divStop),
        .divZero      (divZero),
        .div_hi       (div_hi),
        .div_lo       (div_lo),
        .multStop     (multStop),
        .mult_hi      (mult_hi),
        .mult_lo      (mult_lo),
        .hi_wr        (hi_wr),
        .lo_wr        (lo_wr),
        .wr_data      (wr_data),
        .hi           (hi),
        .lo           (lo),
        .busy         (busy),
        .done         (done),
        .div_zero_exc (div_zero_exc),
        .timeout_exc  (timeout_exc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Architectural reference state
    logic [31:0] m_hi = 32'h0;
    logic [31:0] m_lo = 32'h0;
    logic        m_dz = 1'b0;
    logic        m_to = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk_arch(input string tag);
        chk({tag, ".hi"}, hi, m_hi);
        chk({tag, ".lo"}, lo, m_lo);
        chk({tag, ".dz"}, {31'd0, div_zero_exc}, {31'd0, m_dz});
        chk({tag, ".to"}, {31'd0, timeout_exc}, {31'd0, m_to});
    endtask

    task automatic quiet_inputs();
        start_div  = 1'b0;
        start_mult = 1'b0;
        divStop    = 1'b0;
        divZero    = 1'b0;
        multStop   = 1'b0;
        hi_wr      = 1'b0;
        lo_wr      = 1'b0;
    endtask

    // Idle mthi/mtlo write.
    task automatic write_hl(input logic hw, input logic lw, input logic [31:0] data);
        hi_wr = hw; lo_wr = lw; wr_data = data;
        step();
        hi_wr = 1'b0; lo_wr = 1'b0;
        if (hw) m_hi = data; else m_hi = m_hi;
        if (lw) m_lo = data; else m_lo = m_lo;
        chk("wr.busy", {31'd0, busy}, 32'd0);
        chk_arch("wr");
    endtask

    // Signed divide a/b with d extra idle wait cycles; stale stop/zero values
    // are presented during the first wait cycle. Optionally also requests a
    // multiply and/or an mthi in the start cycle.
    task automatic run_div(input logic signed [31:0] a, input logic signed [31:0] b,
                           input int d, input logic st_stop, input logic st_zero,
                           input logic also_mult, input logic also_wr,
                           input logic [31:0] wd);
        start_div = 1'b1; start_mult = also_mult;
        hi_wr = also_wr; wr_data = wd;
        step();
        start_div = 1'b0; start_mult = 1'b0; hi_wr = 1'b0;
        if (also_wr) m_hi = wd; else m_hi = m_hi;
        m_dz = 1'b0; m_to = 1'b0;
        chk("div.pulse", {31'd0, divControl}, 32'd1);
        chk("div.nomult", {31'd0, multControl}, 32'd0);
        chk("div.busy0", {31'd0, busy}, 32'd1);
        chk("div.done0", {31'd0, done}, 32'd0);
        chk_arch("div.start");
        // First wait cycle: stale completion indications must be ignored.
        divStop = st_stop; divZero = st_zero;
        div_hi = $urandom; div_lo = $urandom;
        step();
        chk("div.pulse_end", {31'd0, divControl}, 32'd0);
        chk("div.stale", {31'd0, done}, 32'd0);
        chk("div.busy1", {31'd0, busy}, 32'd1);
        for (int i = 0; i < d; i++) begin
            divStop = 1'b0; divZero = 1'b0;
            step();
            chk("div.wait", {31'd0, done}, 32'd0);
            chk_arch("div.wait");
        end
        if (b == 32'sd0) begin
            divZero = 1'b1; divStop = st_stop;
            div_hi = $urandom; div_lo = $urandom;
            m_dz = 1'b1;
        end else begin
            divZero = 1'b0; divStop = 1'b1;
            div_hi = a % b; div_lo = a / b;
            m_hi = a % b; m_lo = a / b;
        end
        step();
        divStop = 1'b0; divZero = 1'b0;
        chk("div.done", {31'd0, done}, 32'd1);
        chk("div.busy_done", {31'd0, busy}, 32'd1);
        chk_arch("div.result");
        step();
        chk("div.done_end", {31'd0, done}, 32'd0);
        chk("div.idle", {31'd0, busy}, 32'd0);
        chk_arch("div.after");
    endtask

    // Multiply with product {ph,pl}; d extra wait cycles during which a
    // blocked mthi of 0xDEAD is attempted when wr_busy is set.
    task automatic run_mult(input logic [31:0] ph, input logic [31:0] pl,
                            input int d, input logic wr_busy);
        start_mult = 1'b1;
        multStop = 1'b1;                     // stale from a previous product
        step();
        start_mult = 1'b0;
        m_dz = 1'b0; m_to = 1'b0;
        chk("mul.pulse", {31'd0, multControl}, 32'd1);
        chk("mul.nodiv", {31'd0, divControl}, 32'd0);
        mult_hi = $urandom; mult_lo = $urandom;
        hi_wr = wr_busy; wr_data = 32'h0000_DEAD;
        step();
        chk("mul.stale", {31'd0, done}, 32'd0);
        chk("mul.pulse_end", {31'd0, multControl}, 32'd0);
        chk_arch("mul.busywr");
        for (int i = 0; i < d; i++) begin
            multStop = 1'b0;
            step();
            chk("mul.wait", {31'd0, done}, 32'd0);
            chk_arch("mul.wait");
        end
        hi_wr = 1'b0;
        multStop = 1'b1; mult_hi = ph; mult_lo = pl;
        m_hi = ph; m_lo = pl;
        step();
        multStop = 1'b0;
        chk("mul.done", {31'd0, done}, 32'd1);
        chk_arch("mul.result");
        step();
        chk("mul.idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        quiet_inputs();
        div_hi = 32'h0; div_lo = 32'h0; mult_hi = 32'h0; mult_lo = 32'h0;
        wr_data = 32'h0;
        reset = 1'b1;
        #1;
        chk("rst.hi", hi, 32'h0);
        chk("rst.lo", lo, 32'h0);
        chk("rst.busy", {31'd0, busy}, 32'd0);
        chk("rst.done", {31'd0, done}, 32'd0);
        chk("rst.dctl", {31'd0, divControl}, 32'd0);
        chk("rst.mctl", {31'd0, multControl}, 32'd0);
        chk_arch("rst");
        step();
        reset = 1'b0;
        step();

        // Directed divides and multiply
        run_div(32'sd100, 32'sd7, 0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("div100.hi", hi, 32'd2);
        chk("div100.lo", lo, 32'd14);
        run_div(-32'sd7, 32'sd2, 2, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("divneg.lo", lo, 32'hFFFF_FFFD);
        chk("divneg.hi", hi, 32'hFFFF_FFFF);
        run_div(32'sd55, 32'sd0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        run_mult(32'h1, 32'h2, 1, 1'b1);
        // Both starts together: divide only; mthi in the same start cycle.
        run_div(32'sd9, 32'sd4, 1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1234_5678);
        run_div(32'sd9, 32'sd0, 1, 1'b1, 1'b0, 1'b0, 1'b1, 32'hCAFE_F00D);
        write_hl(1'b1, 1'b1, 32'hA5A5_0001);
        write_hl(1'b0, 1'b1, 32'h0000_0042);

        // Next start clears a held div_zero_exc.
        run_div(32'sd0, 32'sd0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        run_mult(32'hFFFF_0000, 32'h0000_FFFF, 0, 1'b0);

`ifdef HILO_SEQ_TIMEOUT_EN
        // Watchdog: divStop never arrives; abort after TO_CYC wait cycles.
        start_div = 1'b1;
        step();
        start_div = 1'b0;
        m_dz = 1'b0; m_to = 1'b0;
        for (int i = 1; i < TO_CYC; i++) begin
            step();
            chk("to.wait", {31'd0, done}, 32'd0);
        end
        step();
        m_to = 1'b1;
        chk("to.done", {31'd0, done}, 32'd1);
        chk_arch("to.abort");
        step();
        chk("to.idle", {31'd0, busy}, 32'd0);
        run_mult(32'h7, 32'h8, 0, 1'b0);
`endif

        // Randomised mix of operations against the model
        for (int n = 0; n < 24; n++) begin
            case ($urandom_range(0, 2))
                0: begin
                    logic signed [31:0] ra;
                    logic signed [31:0] rb;
                    ra = $urandom;
                    rb = ($urandom_range(0, 4) == 0) ? 32'sd0 : $signed($urandom_range(1, 5000));
                    if ($urandom_range(0, 1) == 1) rb = -rb; else rb = rb;
                    run_div(ra, rb, $urandom_range(0, 3), 1'($urandom), 1'($urandom),
                            1'($urandom), 1'($urandom), $urandom);
                end
                1: run_mult($urandom, $urandom, $urandom_range(0, 3), 1'($urandom));
                default: write_hl(1'($urandom), 1'($urandom), $urandom);
            endcase
        end

        // Reset asserted in the middle of a divide, then a late divStop.
        start_div = 1'b1;
        step();
        start_div = 1'b0;
        step();
        reset = 1'b1;
        #1;
        m_hi = 32'h0; m_lo = 32'h0; m_dz = 1'b0; m_to = 1'b0;
        chk("mrst.busy", {31'd0, busy}, 32'd0);
        chk("mrst.done", {31'd0, done}, 32'd0);
        chk("mrst.dctl", {31'd0, divControl}, 32'd0);
        chk_arch("mrst");
        step();
        reset = 1'b0;
        divStop = 1'b1; div_hi = 32'h1111_1111; div_lo = 32'h2222_2222;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mrst.late_busy", {31'd0, busy}, 32'd0);
            chk("mrst.late_done", {31'd0, done}, 32'd0);
            chk_arch("mrst.late");
        end
        divStop = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
